mu0_control: RTL
================

Name: mu0_control

Overview:
- Sequencing control unit for the MU0 datapath (16-bit ALU with modes pass-Y/add/increment/sub, PC, IR, ACC, X/Y/address muxes).
- Runs the fetch/execute cycle and decodes the 4-bit opcode of the IR.
- Drives ALU mode, mux selects and register enables, and handshakes with a memory that may insert wait states.
- Sits beside mu0_alu inside the MU0 processor top level.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  level; while low, no new instruction fetch starts.
- opcode  input  4  IR[15:12] from datapath.
- acc_n  input  1  ACC negative flag (ACC[15]).
- acc_z  input  1  ACC zero flag.
- mem_ack  input  1  memory completes current access this cycle.
- mem_req  output  1  memory access active.
- mem_wr  output  1  access is a write (valid with mem_req).
- addr_sel  output  1  0 = PC drives address, 1 = IR[11:0].
- x_sel  output  1  ALU X: 0 = ACC, 1 = PC.
- y_sel  output  1  ALU Y: 0 = memory data, 1 = IR[11:0] zero-extended.
- alu_m  output  2  ALU mode: 00 pass Y, 01 X+Y, 10 X+1, 11 X-Y.
- pc_en  output  1  load PC from ALU Q.
- ir_en  output  1  load IR from memory data.
- acc_en  output  1  load ACC from ALU Q.
- halted  output  1  STP executed.
- inst_count  output  CNT_W  retired instructions, wrapping.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT.
- Synchronous reset (overrides everything, including mid-access):
  - State goes to IDLE and inst_count to 0.
  - With state IDLE, all outputs are 0 (halted=0, mem_req=0, alu_m=00).
- IDLE: when run=1, go to FETCH on the next edge; otherwise stay.
- FETCH: mem_req=1, mem_wr=0, addr_sel=0, x_sel=1, alu_m=10.
  - pc_en and ir_en are asserted only in the cycle mem_ack=1 (combinational qualification).
  - On mem_ack, go to EXEC; without mem_ack, hold with all outputs stable.
- EXEC, decoded from opcode (IR latched at end of FETCH); addr_sel=1 for memory ops:
  - 0 LDA: mem_req=1, y_sel=0, alu_m=00, acc_en on mem_ack.
  - 1 STA: mem_req=1, mem_wr=1; ACC is the write data; no enables.
  - 2 ADD: mem_req=1, x_sel=0, y_sel=0, alu_m=01, acc_en on mem_ack.
  - 3 SUB: as ADD but alu_m=11.
  - 4 JMP: no memory access, y_sel=1, alu_m=00, pc_en=1; completes in one cycle.
  - 5 JGE: as JMP but pc_en = ~acc_n.
  - 6 JNE: as JMP but pc_en = ~acc_z.
  - 7 STP: no access; next state HALT.
  - 8–15: treated as NOP; complete in one cycle, no enables.
- EXEC with a memory op waits for mem_ack (outputs held); otherwise completes in its single cycle.
- On completion of a non-STP instruction:
  - inst_count increments, wrapping from 2^CNT_W-1 to 0.
  - Next state is FETCH if run=1, else IDLE.
- STP counts as retired (inst_count increments in its EXEC cycle).
- HALT: halted=1, all other outputs 0; exit only by reset; run is ignored.
- Latency:
  - Minimum instruction is 2 cycles (FETCH + EXEC), plus one cycle per wait state.
  - JMP-class instructions are 2 cycles with zero-wait memory.
- Only one enable pulse per register per instruction; never pc_en and acc_en in the same cycle.
- Flags are sampled in the EXEC cycle (combinational).
- mem_ack outside FETCH/memory EXEC is ignored.
- run dropping mid-instruction does not abort it; the unit finishes and then enters IDLE.

Decomposition:
- Package mu0_pkg:
  - opcode constants (OP_LDA..OP_STP).
  - ALU mode constants (ALU_PASSY=00, ALU_ADD=01, ALU_INC=10, ALU_SUB=11).
  - state enumeration.
- Sub-module mu0_decode: purely combinational opcode-to-control-word decode for EXEC, instantiated once.
- FSM and counter stay in mu0_control.

Test Plan:
- Reset with run=1, then release → FETCH the next cycle, mem_req=1, alu_m=10, x_sel=1; mem_ack in cycle 3 → pc_en=ir_en=1 that cycle only.
- opcode=2 (ADD), mem_ack delayed 3 cycles → mem_req held 4 EXEC cycles, alu_m=01, acc_en high only in the ack cycle, inst_count 0→1.
- opcode=5 JGE with acc_n=1 → pc_en=0, no mem_req; repeat with acc_n=0 → pc_en=1, alu_m=00, y_sel=1.
- opcode=7 STP → HALT next cycle, halted=1, stays across run toggles; reset → IDLE, halted=0, inst_count=0.
- run driven low during a waiting LDA → LDA completes with acc_en on ack, then IDLE, mem_req=0.
- CNT_W=4, 16 JMPs → inst_count wraps from 15 to 0; reset asserted mid-FETCH wait → IDLE next cycle, no enables.

Source files
------------

// File: rtl/mu0_pkg.sv
// mu0_pkg: shared definitions for the MU0 control unit.
//   - opcode constants for IR[15:12]
//   - ALU mode encodings driven on alu_m
//   - control FSM state enumeration
//   - the decoded EXEC control word passed from mu0_decode to mu0_control
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_PASSY = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_INC   = 2'b10;
  localparam logic [1:0] ALU_SUB   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Control word for the EXEC cycle. acc_ld is the intent to load ACC;
  // the top qualifies it with mem_ack.
  typedef struct packed {
    logic       mem_op;
    logic       mem_wr;
    logic       x_sel;
    logic       y_sel;
    logic [1:0] alu_m;
    logic       pc_en;
    logic       acc_ld;
    logic       stop;
  } ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// mu0_decode: combinational opcode-to-control-word decode for the EXEC cycle.
// Ports:
//   opcode_i  IR[15:12]
//   acc_n_i   ACC negative flag (JGE condition)
//   acc_z_i   ACC zero flag (JNE condition)
//   ctrl_o    decoded control word
module mu0_decode
  import mu0_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       acc_n_i,
  input  logic       acc_z_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_LDA: begin
        ctrl_o.mem_op = 1'b1;
        ctrl_o.alu_m  = ALU_PASSY;
        ctrl_o.acc_ld = 1'b1;
      end
      OP_STA: begin
        ctrl_o.mem_op = 1'b1;
        ctrl_o.mem_wr = 1'b1;
      end
      OP_ADD: begin
        ctrl_o.mem_op = 1'b1;
        ctrl_o.alu_m  = ALU_ADD;
        ctrl_o.acc_ld = 1'b1;
      end
      OP_SUB: begin
        ctrl_o.mem_op = 1'b1;
        ctrl_o.alu_m  = ALU_SUB;
        ctrl_o.acc_ld = 1'b1;
      end
      OP_JMP: begin
        ctrl_o.y_sel = 1'b1;
        ctrl_o.pc_en = 1'b1;
      end
      OP_JGE: begin
        ctrl_o.y_sel = 1'b1;
        ctrl_o.pc_en = ~acc_n_i;
      end
      OP_JNE: begin
        ctrl_o.y_sel = 1'b1;
        ctrl_o.pc_en = ~acc_z_i;
      end
      OP_STP: ctrl_o.stop = 1'b1;
      default: ctrl_o = '0;  // 8-15 behave as NOP
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// mu0_control: fetch/execute sequencer for the MU0 datapath.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   run                 while low, no new fetch starts
//   opcode, acc_n, acc_z  IR opcode and ACC flags from the datapath
//   mem_ack             memory completes the current access this cycle
//   mem_req, mem_wr     memory access request / write qualifier
//   addr_sel, x_sel, y_sel, alu_m   datapath mux selects and ALU mode
//   pc_en, ir_en, acc_en            register load enables
//   halted              STP has executed
//   inst_count          retired instruction count (wraps)
//   dbg_state_o         current FSM state for observation
// Memory handshake: a request is held with all control outputs stable
// until the cycle mem_ack=1; that cycle completes the access, and any
// enable tied to the access fires only in that cycle. mem_ack is ignored
// whenever no access is requested.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             acc_n,
  input  logic             acc_z,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             addr_sel,
  output logic             x_sel,
  output logic             y_sel,
  output logic [1:0]       alu_m,
  output logic             pc_en,
  output logic             ir_en,
  output logic             acc_en,
  output logic             halted,
  output logic [CNT_W-1:0] inst_count,
  output state_t           dbg_state_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            dec;
  logic             exec_done;

  mu0_decode u_decode (
    .opcode_i (opcode),
    .acc_n_i  (acc_n),
    .acc_z_i  (acc_z),
    .ctrl_o   (dec)
  );

  // Outputs are a function of the registered state plus the cycle's
  // mem_ack/flags, so enables land in the exact cycle the data is valid.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    addr_sel  = 1'b0;
    x_sel     = 1'b0;
    y_sel     = 1'b0;
    alu_m     = ALU_PASSY;
    pc_en     = 1'b0;
    ir_en     = 1'b0;
    acc_en    = 1'b0;
    halted    = 1'b0;
    exec_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        x_sel   = 1'b1;
        alu_m   = ALU_INC;
        pc_en   = mem_ack;
        ir_en   = mem_ack;
        if (mem_ack) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        mem_req   = dec.mem_op;
        mem_wr    = dec.mem_wr;
        addr_sel  = dec.mem_op;
        x_sel     = dec.x_sel;
        y_sel     = dec.y_sel;
        alu_m     = dec.alu_m;
        pc_en     = dec.pc_en;
        acc_en    = dec.acc_ld & mem_ack;
        // Non-memory instructions finish in their single EXEC cycle.
        exec_done = ~dec.mem_op | mem_ack;
        if (exec_done) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (dec.stop)  state_d = ST_HALT;
          else if (run)  state_d = ST_FETCH;
          else           state_d = ST_IDLE;
        end
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inst_count  = cnt_q;
  assign dbg_state_o = state_q;

endmodule
